vec_issue_unit: RTL and testbench

VEC_ISSUE_UNIT -- requirements
Module: vec_issue_unit

---
 rtl/vec_issue_unit.sv | 187 ++++++++++++++++++
 tb/tb_vec_issue_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_unit.sv
// Vector issue unit: holds one scalar-dispatched vector instruction, issues it, waits for completion, returns a result.
// Optional feature: define VEC_ISSUE_TIMEOUT_EN to abandon an issue after TIMEOUT_CYCLES cycles in WAIT_ACK.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module vec_issue_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [`XLEN-1:0]  disp_instruction,
    input  logic [`XLEN-1:0]  disp_rs1_data,
    input  logic [`XLEN-1:0]  disp_rs2_data,
    output logic              disp_ready,
    output logic              inst_valid,
    output logic [`XLEN-1:0]  instruction,
    output logic [`XLEN-1:0]  rs1_data,
    output logic [`XLEN-1:0]  rs2_data,
    input  logic              vec_pro_ready,
    input  logic              is_vec,
    input  logic              vec_pro_ack,
    input  logic [`XLEN-1:0]  csr_out,
    output logic              scalar_pro_ready,
    output logic              result_valid,
    output logic [`XLEN-1:0]  result_data,
    output logic              result_illegal,
    output logic              result_timeout,
    input  logic              result_ready,
    output logic [31:0]       issue_count,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // the valid side holds its payload stable until that cycle.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_RESP     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [`XLEN-1:0]  instr_q, instr_d;
    logic [`XLEN-1:0]  rs1_q, rs1_d;
    logic [`XLEN-1:0]  rs2_q, rs2_d;
    logic [`XLEN-1:0]  res_data_q, res_data_d;
    logic              res_illegal_q, res_illegal_d;
    logic [31:0]       count_q, count_d;
    logic              timeout_hit;

`ifdef VEC_ISSUE_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]     timer_q, timer_d;
    logic              res_timeout_q, res_timeout_d;

    // Terminal count reached on the last of TIMEOUT_CYCLES waiting cycles.
    assign timeout_hit    = (state_q == S_WAIT_ACK) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign result_timeout = res_timeout_q;
`else
    logic [31:0]       unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign result_timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            instr_q       <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            res_data_q    <= '0;
            res_illegal_q <= 1'b0;
            count_q       <= '0;
`ifdef VEC_ISSUE_TIMEOUT_EN
            timer_q       <= '0;
            res_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            res_data_q    <= res_data_d;
            res_illegal_q <= res_illegal_d;
            count_q       <= count_d;
`ifdef VEC_ISSUE_TIMEOUT_EN
            timer_q       <= timer_d;
            res_timeout_q <= res_timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (disp_valid) state_d = S_ISSUE;
            S_ISSUE: begin
                if (vec_pro_ready) begin
                    if (!is_vec || vec_pro_ack) state_d = S_RESP;
                    else                        state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: if (vec_pro_ack || timeout_hit) state_d = S_RESP;
            S_RESP:     if (result_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        disp_ready       = (state_q == S_IDLE);
        inst_valid       = (state_q == S_ISSUE);
        scalar_pro_ready = (state_q == S_WAIT_ACK);
        result_valid     = (state_q == S_RESP);
    end

    // Payload and result registers; an ack seen outside ISSUE-handshake/WAIT_ACK is ignored.
    always_comb begin
        instr_d       = instr_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        res_data_d    = res_data_q;
        res_illegal_d = res_illegal_q;
        count_d       = count_q;
`ifdef VEC_ISSUE_TIMEOUT_EN
        timer_d       = timer_q;
        res_timeout_d = res_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (disp_valid) begin
                    instr_d = disp_instruction;
                    rs1_d   = disp_rs1_data;
                    rs2_d   = disp_rs2_data;
                end
            end
            S_ISSUE: begin
                if (vec_pro_ready) begin
                    if (!is_vec) begin
                        res_illegal_d = 1'b1;
                        res_data_d    = '0;
                    end else if (vec_pro_ack) begin
                        res_data_d    = csr_out;
                    end
`ifdef VEC_ISSUE_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            S_WAIT_ACK: begin
                if (vec_pro_ack) begin
                    res_data_d = csr_out;
                end else if (timeout_hit) begin
                    res_data_d = '0;
`ifdef VEC_ISSUE_TIMEOUT_EN
                    res_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (result_ready) begin
                    res_illegal_d = 1'b0;
                    count_d       = count_q + 32'd1;
`ifdef VEC_ISSUE_TIMEOUT_EN
                    res_timeout_d = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

    assign instruction    = instr_q;
    assign rs1_data       = rs1_q;
    assign rs2_data       = rs2_q;
    assign result_data    = res_data_q;
    assign result_illegal = res_illegal_q;
    assign issue_count    = count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_vec_issue_unit.sv
// Self-checking bench for vec_issue_unit: directed scenarios plus randomized transactions, scoreboarded results.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_vec_issue_unit;
    localparam int XL = `XLEN;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          disp_valid = 1'b0;
    logic [XL-1:0] disp_instruction = '0;
    logic [XL-1:0] disp_rs1_data = '0;
    logic [XL-1:0] disp_rs2_data = '0;
    logic          disp_ready;
    logic          inst_valid;
    logic [XL-1:0] instruction;
    logic [XL-1:0] rs1_data;
    logic [XL-1:0] rs2_data;
    logic          vec_pro_ready = 1'b0;
    logic          is_vec = 1'b0;
    logic          vec_pro_ack = 1'b0;
    logic [XL-1:0] csr_out = '0;
    logic          scalar_pro_ready;
    logic          result_valid;
    logic [XL-1:0] result_data;
    logic          result_illegal;
    logic          result_timeout;
    logic          result_ready = 1'b0;
    logic [31:0]   issue_count;
    logic [1:0]    dbg_state;

    int            checks = 0;
    int            failures = 0;
    logic [XL+1:0] exp_q[$];       // {timeout, illegal, data}
    logic [31:0]   exp_count = '0;

    vec_issue_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_instruction(disp_instruction),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_ready(disp_ready), .inst_valid(inst_valid),
        .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .vec_pro_ready(vec_pro_ready), .is_vec(is_vec), .vec_pro_ack(vec_pro_ack),
        .csr_out(csr_out), .scalar_pro_ready(scalar_pro_ready),
        .result_valid(result_valid), .result_data(result_data),
        .result_illegal(result_illegal), .result_timeout(result_timeout),
        .result_ready(result_ready), .issue_count(issue_count), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare each consumed result against the queue head.
    always @(negedge clk) begin
        if (!reset && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 64'd1, 64'd0);
            end else begin
                logic [XL+1:0] e;
                e = exp_q.pop_front();
                check_eq("result_data", result_data, e[XL-1:0]);
                check_eq("result_illegal", result_illegal, e[XL]);
                check_eq("result_timeout", result_timeout, e[XL+1]);
                exp_count++;
            end
        end
    end

    // Driver: offer one dispatch from IDLE; returns in ISSUE.
    task automatic dispatch(input logic [XL-1:0] i, input logic [XL-1:0] a, input logic [XL-1:0] b);
        check_eq("disp_ready_idle", disp_ready, 1);
        disp_valid = 1'b1;
        disp_instruction = i;
        disp_rs1_data = a;
        disp_rs2_data = b;
        tick();
        disp_valid = 1'b0;
        check_eq("inst_valid_issue", inst_valid, 1);
        check_eq("payload_instr", instruction, i);
        check_eq("payload_rs1", rs1_data, a);
        check_eq("payload_rs2", rs2_data, b);
        check_eq("disp_ready_busy", disp_ready, 0);
    endtask

    // Driver: full transaction. ack_dly=0 means ack in the handshake cycle.
    task automatic run_txn(input logic [XL-1:0] i, input logic [XL-1:0] a, input logic [XL-1:0] b,
                           input int rdy_dly, input bit legal, input int ack_dly,
                           input int res_dly, input logic [XL-1:0] csr);
        dispatch(i, a, b);
        result_ready = 1'b0;
        repeat (rdy_dly) begin
            vec_pro_ready = 1'b0;
            vec_pro_ack = 1'($urandom_range(0, 1));
            disp_valid = 1'b1;
            disp_instruction = XL'($urandom);
            tick();
            check_eq("stall_inst_valid", inst_valid, 1);
            check_eq("stall_instr", instruction, i);
            check_eq("stall_rs1", rs1_data, a);
            check_eq("stall_rs2", rs2_data, b);
            check_eq("stall_disp_ready", disp_ready, 0);
        end
        disp_valid = 1'b0;
        vec_pro_ack = 1'b0;
        vec_pro_ready = 1'b1;
        is_vec = legal;
        if (!legal) begin
            csr_out = XL'($urandom);
            exp_q.push_back({1'b0, 1'b1, {XL{1'b0}}});
            tick();
        end else if (ack_dly == 0) begin
            vec_pro_ack = 1'b1;
            csr_out = csr;
            exp_q.push_back({1'b0, 1'b0, csr});
            tick();
        end else begin
            csr_out = ~csr;
            tick();
            vec_pro_ready = 1'b0;
            check_eq("wait_scalar_ready", scalar_pro_ready, 1);
            check_eq("wait_inst_valid", inst_valid, 0);
            repeat (ack_dly - 1) begin
                tick();
                check_eq("wait_hold", scalar_pro_ready, 1);
            end
            vec_pro_ack = 1'b1;
            csr_out = csr;
            exp_q.push_back({1'b0, 1'b0, csr});
            tick();
        end
        vec_pro_ack = 1'b0;
        vec_pro_ready = 1'b0;
        is_vec = 1'b0;
        check_eq("resp_valid", result_valid, 1);
        check_eq("resp_scalar_ready", scalar_pro_ready, 0);
        repeat (res_dly) begin
            disp_valid = 1'b1;
            tick();
            check_eq("resp_hold_valid", result_valid, 1);
            check_eq("resp_hold_data", result_data, legal ? csr : '0);
            check_eq("resp_disp_ready", disp_ready, 0);
        end
        disp_valid = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_eq("back_idle", disp_ready, 1);
        check_eq("idle_result_valid", result_valid, 0);
        check_eq("idle_illegal_clr", result_illegal, 0);
        check_eq("issue_count", issue_count, exp_count);
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_disp_ready", disp_ready, 1);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_scalar_ready", scalar_pro_ready, 0);
        check_eq("rst_result_valid", result_valid, 0);
        check_eq("rst_result_data", result_data, 0);
        check_eq("rst_issue_count", issue_count, 0);
        check_eq("rst_instr", instruction, 0);

        // Basic issue with ack three cycles after the handshake
        run_txn(32'h0200_8057, 32'd5, 32'd0, 0, 1'b1, 3, 0, 32'h10);
        check_eq("count_after_first", issue_count, 1);
        // Issue stalled 10 cycles, handshake on the 11th
        run_txn(32'h1234_5678, 32'hAAAA_0001, 32'h5555_0002, 10, 1'b1, 2, 0, 32'h77);
        // Illegal instruction: immediate response
        run_txn(32'hDEAD_BEEF, 32'd1, 32'd2, 0, 1'b0, 0, 0, 32'h0);
        // Handshake and ack together: 2-cycle latency
        run_txn(32'h0000_0057, 32'd9, 32'd8, 0, 1'b1, 0, 0, 32'hAB);
        // Result back-pressure for 5 cycles
        run_txn(32'h0300_0057, 32'd3, 32'd4, 1, 1'b1, 1, 5, 32'hC0DE);

        // Reset during WAIT_ACK
        dispatch(32'h0400_0057, 32'd7, 32'd6);
        vec_pro_ready = 1'b1;
        is_vec = 1'b1;
        tick();
        vec_pro_ready = 1'b0;
        check_eq("dbg_wait", dbg_state, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        is_vec = 1'b0;
        exp_count = '0;
        check_eq("mid_rst_scalar_ready", scalar_pro_ready, 0);
        check_eq("mid_rst_result_valid", result_valid, 0);
        check_eq("mid_rst_result_data", result_data, 0);
        check_eq("mid_rst_instr", instruction, 0);
        check_eq("mid_rst_rs1", rs1_data, 0);
        check_eq("mid_rst_count", issue_count, 0);
        check_eq("mid_rst_disp_ready", disp_ready, 1);

        // No acknowledge at all
        dispatch(32'h0500_0057, 32'd1, 32'd1);
        vec_pro_ready = 1'b1;
        is_vec = 1'b1;
        tick();
        vec_pro_ready = 1'b0;
        is_vec = 1'b0;
`ifdef VEC_ISSUE_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            check_eq("to_waiting", scalar_pro_ready, 1);
            if (k == 7) begin
                exp_q.push_back({1'b1, 1'b0, {XL{1'b0}}});
                result_ready = 1'b1;
            end
            tick();
        end
        check_eq("to_result_valid", result_valid, 1);
        check_eq("to_flag", result_timeout, 1);
        tick();
        result_ready = 1'b0;
        vec_pro_ack = 1'b1;
        tick();
        vec_pro_ack = 1'b0;
        check_eq("late_ack_idle", disp_ready, 1);
        check_eq("late_ack_no_result", result_valid, 0);
        check_eq("to_count", issue_count, exp_count);
`else
        repeat (28) begin
            tick();
            check_eq("no_to_waiting", scalar_pro_ready, 1);
        end
        check_eq("no_to_result_valid", result_valid, 0);
        check_eq("no_to_flag", result_timeout, 0);
        vec_pro_ack = 1'b1;
        csr_out = 32'h600D;
        exp_q.push_back({1'b0, 1'b0, 32'h600D});
        result_ready = 1'b1;
        tick();
        vec_pro_ack = 1'b0;
        check_eq("no_to_resp", result_valid, 1);
        tick();
        result_ready = 1'b0;
        check_eq("no_to_idle", disp_ready, 1);
        check_eq("no_to_count", issue_count, exp_count);
`endif

        // Randomized transactions
        for (int n = 0; n < 15; n++) begin
            run_txn(XL'($urandom), XL'($urandom), XL'($urandom),
                    $urandom_range(0, 4), 1'($urandom_range(0, 3) != 0),
                    $urandom_range(0, 4), $urandom_range(0, 3), XL'($urandom));
        end

        tick();
        check_eq("queue_empty", 64'(exp_q.size()), 0);
        check_eq("final_count", issue_count, exp_count);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
